// File: rtl/game_pkg.sv
// Shared game definitions: game-control state codes and BCD helpers used by
// the round timer and the game-control FSM.
package game_pkg;

  typedef enum logic [2:0] {
    GS_IDLE     = 3'd0,
    GS_MENU     = 3'd1,
    GS_RUNGAME  = 3'd2,
    GS_GAMEOVER = 3'd3
  } game_state_e;

  // Codes 4..7 are unassigned and behave like idle.
  function automatic logic gs_is_idle_like(input logic [2:0] gs);
    return !((gs == GS_RUNGAME) || (gs == GS_GAMEOVER));
  endfunction

  // Two-digit BCD decrement done digit-wise; ones wrap 0 -> 9 and borrow from tens.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/game_timer_tick_gen.sv
// Prescaler producing a registered one-cycle pulse every CLK_HZ enabled cycles.
// The pulse appears the cycle after the prescaler wraps, so an enable drop
// on the wrap cycle holds the count and no pulse is produced.
module tick_gen #(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            PW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TOP = PW'(CLK_HZ - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next prescaler value and wrap pulse.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == TOP) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Prescaler and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_timer.sv
// Round countdown timer: BCD seconds display, 1 Hz tick, low-time warning
// and game-over flag for the game-control FSM.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_LOADED  | digits hold the round length, waiting for rungame
// ST_RUNNING | counting down one second per tick (pause/gameover freeze)
// ST_EXPIRED | reached 00, GO held until idle/menu returns to LOADED
module game_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 25_000_000,
  parameter int GAME_SECONDS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic       pause,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       tick_1hz,
  output logic       warning,
  output logic       GO
);

  typedef enum logic [1:0] {
    ST_LOADED  = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } timer_state_e;

  localparam logic [3:0] LOAD_TENS = 4'(GAME_SECONDS / 10);
  localparam logic [3:0] LOAD_ONES = 4'(GAME_SECONDS % 10);

  timer_state_e state_q, state_d;
  logic [3:0]   tens_q, tens_d, ones_q, ones_d;
  logic         warn_q, warn_d, go_q, go_d;
  logic         run_req, abort, tick, tg_clear, tg_enable;

  assign run_req = (game_state == GS_RUNGAME);
  assign abort   = gs_is_idle_like(game_state);

  // Prescaler runs only while counting; it restarts from 0 on entry to RUNNING,
  // so the entry edge already counts as the first prescaler cycle.
  assign tg_clear  = (state_d != ST_RUNNING);
  assign tg_enable = (state_d == ST_RUNNING) && run_req && !pause;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (tg_clear),
    .enable (tg_enable),
    .tick   (tick)
  );

  // Next state, digits and flags; every output is registered from these.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      ST_LOADED: begin
        if (run_req) state_d = (GAME_SECONDS == 0) ? ST_EXPIRED : ST_RUNNING;
      end
      ST_RUNNING: begin
        if (abort) state_d = ST_LOADED;
        else if (tick && (tens_q == 4'd0) && (ones_q == 4'd1)) state_d = ST_EXPIRED;
      end
      ST_EXPIRED: begin
        if (abort) state_d = ST_LOADED;
      end
      default: state_d = ST_LOADED;
    endcase

    case (state_d)
      ST_LOADED: begin
        tens_d = LOAD_TENS;
        ones_d = LOAD_ONES;
      end
      ST_EXPIRED: begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end
      default: begin
        if (tick) {tens_d, ones_d} = bcd_dec({tens_q, ones_q});
      end
    endcase

    warn_d = (state_d == ST_RUNNING) &&
             ((tens_d == 4'd0) || ((tens_d == 4'd1) && (ones_d == 4'd0)));
    go_d   = (state_d == ST_EXPIRED);
  end

  // State, digit and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOADED;
      tens_q  <= LOAD_TENS;
      ones_q  <= LOAD_ONES;
      warn_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      warn_q  <= warn_d;
      go_q    <= go_d;
    end
  end

  assign time_tens = tens_q;
  assign time_ones = ones_q;
  assign tick_1hz  = tick;
  assign warning   = warn_q;
  assign GO        = go_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer (CLK_HZ=4): scoreboard of expected post-tick values
// checked by a tick monitor, plus directed checks of reset, pause, abort and
// a zero-length-round instance.
module tb_game_timer;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] game_state = 3'd0;
  logic       pause = 1'b0;
  logic [3:0] time_tens, time_ones;
  logic       tick_1hz, warning, GO;

  logic       reset0 = 1'b1;
  logic [2:0] game_state0 = 3'd0;
  logic       pause0 = 1'b0;
  logic [3:0] tens0, ones0;
  logic       tick0, warn0, go0;

  game_timer #(.CLK_HZ(4), .GAME_SECONDS(12)) dut (
    .clk(clk), .reset(reset), .game_state(game_state), .pause(pause),
    .time_tens(time_tens), .time_ones(time_ones), .tick_1hz(tick_1hz),
    .warning(warning), .GO(GO)
  );

  game_timer #(.CLK_HZ(4), .GAME_SECONDS(0)) dut0 (
    .clk(clk), .reset(reset0), .game_state(game_state0), .pause(pause0),
    .time_tens(tens0), .time_ones(ones0), .tick_1hz(tick0),
    .warning(warn0), .GO(go0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tens;
    int ones;
    int warn;
    int go;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected display after each tick from 'from' down to 'to'.
  task automatic push_run(input int from, input int to);
    for (int v = from; v >= to; v--) begin
      exp_t e;
      e.tens = v / 10;
      e.ones = v % 10;
      e.warn = (v <= 10 && v != 0) ? 1 : 0;
      e.go   = (v == 0) ? 1 : 0;
      sb.push_back(e);
    end
  endtask

  task automatic wait_val(input int v, input int budget);
    int n = 0;
    while ((int'(time_tens) * 10 + int'(time_ones)) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("reach_value", int'(time_tens) * 10 + int'(time_ones), v);
  endtask

  // Monitor: the cycle after each tick pulse, compare the updated display.
  logic tick_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (tick_prev) begin
      check("tick_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tick_tens", time_tens, e.tens);
        check("tick_ones", time_ones, e.ones);
        check("tick_warning", warning, e.warn);
        check("tick_go", GO, e.go);
      end
    end
    tick_prev <= tick_1hz;
  end

  initial begin
    int t0;
    int n;
    repeat (3) @(negedge clk);
    check("rst_tens", time_tens, 1);
    check("rst_ones", time_ones, 2);
    check("rst_tick", tick_1hz, 0);
    check("rst_warning", warning, 0);
    check("rst_go", GO, 0);
    check("rst0_ones", ones0, 0);
    check("rst0_go", go0, 0);
    reset = 1'b0;
    reset0 = 1'b0;
    @(negedge clk);
    check("loaded_go", GO, 0);

    // Full round: tick every 4th cycle, GO 48 cycles after entry.
    push_run(11, 0);
    game_state = GS_RUNGAME;
    @(negedge clk);
    t0 = cyc;
    check("entry_tens", time_tens, 1);
    check("entry_ones", time_ones, 2);
    check("entry_warning", warning, 0);
    n = 0;
    while (!GO && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("go_latency", cyc - t0, 48);

    // Gameover holds expiry; idle reloads.
    game_state = GS_GAMEOVER;
    repeat (10) begin
      @(negedge clk);
      check("exp_go", GO, 1);
      check("exp_digits", int'(time_tens) * 10 + int'(time_ones), 0);
      check("exp_warning", warning, 0);
    end
    check("sb_drained_run1", sb.size(), 0);
    game_state = GS_IDLE;
    @(negedge clk);
    check("reload_go", GO, 0);
    check("reload_tens", time_tens, 1);
    check("reload_ones", time_ones, 2);

    // Pause at 09 mid-prescale for 7 cycles, then resume from frozen count.
    push_run(11, 9);
    game_state = GS_RUNGAME;
    wait_val(9, 100);
    t0 = cyc;
    pause = 1'b1;
    repeat (7) begin
      @(negedge clk);
      check("pause_digits", int'(time_tens) * 10 + int'(time_ones), 9);
      check("pause_tick", tick_1hz, 0);
      check("pause_warning", warning, 1);
    end
    pause = 1'b0;
    push_run(8, 5);
    wait_val(8, 50);
    check("resume_delay", cyc - t0, 11);

    // Abort to menu at 05.
    wait_val(5, 50);
    game_state = GS_MENU;
    @(negedge clk);
    check("abort_tens", time_tens, 1);
    check("abort_ones", time_ones, 2);
    check("abort_go", GO, 0);
    check("abort_warning", warning, 0);

    // Reset at 03 with pause high.
    push_run(11, 3);
    game_state = GS_RUNGAME;
    wait_val(3, 100);
    check("pre_reset_warning", warning, 1);
    pause = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tens", time_tens, 1);
    check("mid_rst_ones", time_ones, 2);
    check("mid_rst_tick", tick_1hz, 0);
    check("mid_rst_warning", warning, 0);
    check("mid_rst_go", GO, 0);
    @(negedge clk);
    check("mid_rst_hold_ones", time_ones, 2);
    reset = 1'b0;
    pause = 1'b0;
    game_state = GS_IDLE;
    repeat (2) @(negedge clk);
    check("sb_drained_end", sb.size(), 0);

    // Zero-length round: GO one cycle after rungame, never a tick.
    game_state0 = GS_RUNGAME;
    @(negedge clk);
    check("zero_go", go0, 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick0 || !go0 || warn0) n++;
    end
    check("zero_quiet_cycles", n, 0);
    game_state0 = 3'd6;
    @(negedge clk);
    check("zero_idle_like_go", go0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter CLK_HZ, default 25_000_000, clock cycles per game second.
REQ-002 Parameter GAME_SECONDS, default 60, round length in seconds; legal range 0..99.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 game_state  input  3  game-control state code: idle=0, menu=1, rungame=2, gameover=3.
REQ-006 pause  input  1  level; freezes the countdown while high.
REQ-007 time_tens  output  4  BCD tens digit of remaining seconds.
REQ-008 time_ones  output  4  BCD ones digit of remaining seconds.
REQ-009 tick_1hz  output  1  one-cycle pulse per counted second.
REQ-010 warning  output  1  high while RUNNING and remaining time is 10 s or less.
REQ-011 GO  output  1  game-over flag, consumed by the game-control FSM.

Function
REQ-012 Internal FSM SHALL have three states: LOADED, RUNNING and EXPIRED.
REQ-013 LOADED: digits hold GAME_SECONDS, prescaler = 0, GO = 0; game_state == rungame -> RUNNING on the next edge.
REQ-014 RUNNING: while pause = 0, prescaler increments each cycle; at CLK_HZ-1 it wraps to 0 and tick_1hz pulses for that one cycle.
REQ-015 On each tick the BCD value SHALL decrement by 1, with registered update visible the cycle after tick_1hz.
- Ones 0 -> 9 with tens decremented.
- No binary intermediate.
REQ-016 A tick that takes the value from 01 to 00 SHALL move the FSM to EXPIRED and set GO = 1 on the same edge.
REQ-017 EXPIRED: digits hold 00, tick_1hz = 0 and GO = 1 until game_state is idle or menu; then go to LOADED, reload digits and clear GO on that edge.
REQ-018 RUNNING with game_state idle or menu (round aborted) -> LOADED next edge with reload; gameover without expiry -> hold digits and prescaler frozen.
REQ-019 pause = 1 in RUNNING freezes the prescaler and the digits.
- tick_1hz stays 0.
- A pause asserted on the wrap cycle suppresses that tick.
REQ-020 GAME_SECONDS = 0: LOADED with game_state == rungame -> EXPIRED directly, GO = 1 one cycle after rungame is first sampled.
REQ-021 game_state codes 4..7 SHALL be treated as idle.
REQ-022 warning = RUNNING and (tens == 0 or (tens == 1 and ones == 0)); low in LOADED and EXPIRED.
REQ-023 Prescaler width SHALL be $clog2(CLK_HZ) bits; it SHALL never exceed CLK_HZ-1.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 reset SHALL dominate all other inputs on any edge, including mid-round and in EXPIRED.
REQ-026 Reset values:
- FSM = LOADED
- prescaler = 0
- digits = GAME_SECONDS in BCD
- tick_1hz = 0
- warning = 0
- GO = 0

Structure
REQ-027 The game-state enum (idle, menu, rungame, gameover; 3-bit encoding) SHALL live in shared package game_pkg, used by this block and the game-control FSM.
REQ-028 The timer FSM state enum SHALL be local to game_timer.
REQ-029 Prescaler and tick generation SHALL be one sub-module, tick_gen (parameter CLK_HZ; inputs clk, reset, clear, enable; output tick).

Verification (CLK_HZ=4, GAME_SECONDS=12)
REQ-030 reset, then game_state=rungame held -> tick_1hz every 4th cycle; digits 12,11,...,01,00; warning from 10; GO=1 on the edge reaching 00, 48 cycles after entry.
REQ-031 After expiry, game_state=gameover for 10 cycles then idle -> GO stays 1, digits 00; then GO=0 and digits 12 on the idle edge.
REQ-032 pause=1 for 7 cycles at value 09 mid-prescale -> no tick, digits stay 09; count resumes from the frozen prescaler value.
REQ-033 Round aborted to menu at value 05 -> LOADED, digits 12, GO=0, warning=0 next cycle.
REQ-034 reset asserted at value 03 with pause=1 -> all outputs at reset values next cycle.
REQ-035 GAME_SECONDS=0 build, game_state=rungame -> GO=1 after one cycle, tick_1hz never pulses.
